// File: rtl/writeback_queue_if.sv
// Bundle of producer handshake, register-file write port and forwarding
// read ports shared between the writeback queue and its neighbours.
interface writeback_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rw;
    logic [63:0] in_data;
    logic        reg_wr;
    logic [4:0]  rw;
    logic [63:0] bus_w;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [63:0] rf_bus_a;
    logic [63:0] rf_bus_b;
    logic [63:0] bus_a;
    logic [63:0] bus_b;

    modport master (
        output in_valid, in_rw, in_data, ra, rb, rf_bus_a, rf_bus_b,
        input  in_ready, reg_wr, rw, bus_w, bus_a, bus_b
    );

    modport slave (
        input  in_valid, in_rw, in_data, ra, rb, rf_bus_a, rf_bus_b,
        output in_ready, reg_wr, rw, bus_w, bus_a, bus_b
    );
endinterface

// File: rtl/writeback_queue.sv
// Circular queue of pending register writes that drains one entry per cycle
// into the register file and forwards pending data onto the read buses.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    writeback_queue_if.slave         wbq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head_reg;
    logic [AW-1:0] tail_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    logic [4:0]  rw_mem   [DEPTH];
    logic [63:0] data_mem [DEPTH];

    logic do_enq;
    logic do_deq;

    assign empty        = (count_reg == '0);
    assign count        = count_reg;
    assign wbq.in_ready = (count_reg < CW'(DEPTH));

    // Register-31 writes complete the handshake but never occupy an entry.
    assign do_enq = wbq.in_valid && wbq.in_ready && (wbq.in_rw != 5'd31);
    assign do_deq = !empty;

    always_comb begin
        count_next = count_reg;
        case ({do_enq, do_deq})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (do_deq)
                head_reg <= head_reg + 1'b1;
            if (do_enq)
                tail_reg <= tail_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            rw_mem[tail_reg]   <= wbq.in_rw;
            data_mem[tail_reg] <= wbq.in_data;
        end
    end

    assign wbq.reg_wr = !empty;
    assign wbq.rw     = empty ? 5'd0  : rw_mem[head_reg];
    assign wbq.bus_w  = empty ? 64'd0 : data_mem[head_reg];

    // Slot gi is the gi-th oldest entry; higher gi means younger.
    logic [AW-1:0]    slot_idx [DEPTH];
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] hit_a;
    logic [DEPTH-1:0] hit_b;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign slot_idx[gi] = head_reg + AW'(gi);
            assign live[gi]     = (CW'(gi) < count_reg);
            assign hit_a[gi]    = live[gi] && (rw_mem[slot_idx[gi]] == wbq.ra);
            assign hit_b[gi]    = live[gi] && (rw_mem[slot_idx[gi]] == wbq.rb);
        end
    endgenerate

    logic [63:0] fwd_a;
    logic [63:0] fwd_b;

    always_comb begin
        fwd_a = wbq.rf_bus_a;
        fwd_b = wbq.rf_bus_b;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit_a[i])
                fwd_a = data_mem[slot_idx[i]];
            if (hit_b[i])
                fwd_b = data_mem[slot_idx[i]];
        end
        if (wbq.ra == 5'd31)
            fwd_a = 64'd0;
        if (wbq.rb == 5'd31)
            fwd_b = 64'd0;
    end

    assign wbq.bus_a = fwd_a;
    assign wbq.bus_b = fwd_b;
endmodule
